// File: rtl/red_pitaya_dna_pkg.sv
// red_pitaya_dna_pkg: shared constants and state type for the DNA_PORT readout sequencer
package red_pitaya_dna_pkg;
    localparam int DNA_W_DEF = 57;
    localparam logic [DNA_W_DEF-1:0] SIM_DNA_VALUE = 57'h0823456789ABCDE;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/red_pitaya_dna_phase.sv
// red_pitaya_dna_phase: DNA clock divider with end-of-phase strobes, held low while disabled
module red_pitaya_dna_phase import red_pitaya_dna_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic dna_clk_o,
    output logic low_last_o,
    output logic high_last_o
);
    logic [7:0] cnt_q, cnt_d;
    logic       hi_q, hi_d;
    logic       wrap;

    // count CLK_DIV cycles per half-period; disabling snaps back to the start of a low phase
    always_comb begin
        wrap  = cnt_q == 8'(CLK_DIV - 1);
        cnt_d = (en_i && !wrap) ? cnt_q + 8'd1 : 8'd0;
        hi_d  = en_i && (hi_q ^ wrap);
    end

    // divider state
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= 8'd0;
            hi_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
        end
    end

    assign dna_clk_o   = hi_q;
    assign low_last_o  = wrap && !hi_q;
    assign high_last_o = wrap && hi_q;
endmodule

// File: rtl/red_pitaya_dna_ctrl.sv
// red_pitaya_dna_ctrl: DNA_PORT read/shift sequencer that deserialises the device identifier
module red_pitaya_dna_ctrl import red_pitaya_dna_pkg::*; #(
    parameter int DNA_W      = DNA_W_DEF,
    parameter int CLK_DIV    = 4,
    parameter bit AUTO_START = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             dna_dout_i,
    output logic             dna_clk_o,
    output logic             dna_read_o,
    output logic             dna_shift_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic [DNA_W-1:0] dna_o
);
    localparam int CW = $clog2(DNA_W);

    state_t             state_q, state_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DNA_W-1:0]   shreg_q, shreg_d, dna_q, dna_d, sample;
    logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic               read_q, read_d, shift_q, shift_d, auto_q, auto_d;
    logic               low_last, high_last, go, fin;

    assign go  = state_q == IDLE && (start_i || auto_q);
    assign fin = state_q == SHIFT && low_last && bit_cnt_q == CW'(DNA_W - 1);

    red_pitaya_dna_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .en_i        (state_q != IDLE && !fin),
        .dna_clk_o   (dna_clk_o),
        .low_last_o  (low_last),
        .high_last_o (high_last)
    );

    // sequencing: one load period, then one sample per low phase, finishing on the last sample
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        dna_d     = dna_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        read_d    = read_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        auto_d    = 1'b0;
        sample    = {shreg_q[DNA_W-2:0], dna_dout_i};
        case (state_q)
            IDLE: if (go) begin
                state_d = LOAD;
                busy_d  = 1'b1;
                valid_d = 1'b0;
                read_d  = 1'b1;
            end
            LOAD: if (high_last) begin
                state_d = SHIFT;
                read_d  = 1'b0;
                shift_d = 1'b1;
            end
            SHIFT: if (low_last) begin
                shreg_d   = sample;
                bit_cnt_d = fin ? '0 : bit_cnt_q + 1'b1;
                if (fin) begin
                    dna_d   = sample;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    shift_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // register state and every output
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            dna_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            read_q    <= 1'b0;
            shift_q   <= 1'b0;
            auto_q    <= AUTO_START;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            dna_q     <= dna_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            read_q    <= read_d;
            shift_q   <= shift_d;
            auto_q    <= auto_d;
        end
    end

    assign dna_read_o  = read_q;
    assign dna_shift_o = shift_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign valid_o     = valid_q;
    assign dna_o       = dna_q;
endmodule

// File: tb/tb_red_pitaya_dna_ctrl.sv
// tb_red_pitaya_dna_ctrl: three configurations checked cycle by cycle against a timeline model
module tb_red_pitaya_dna_ctrl;
    logic       clk = 1'b0;
    logic [2:0] rstn = 3'b000, start = 3'b000;
    logic [2:0] dout, dclk, rd, sh, busy, done, valid;
    logic [56:0] dna [3];
    logic [56:0] val [3];

    int dv [3]    = '{4, 4, 2};
    int lit_l [3] = '{460, 460, 230};
    bit au [3]    = '{1'b1, 1'b0, 1'b0};

    int rem [3]  = '{default: 0};
    int k [3]    = '{default: 0};
    int nexp [3] = '{default: 0};
    bit pend [3] = '{default: 1'b0};
    logic [2:0] e_busy = '0, e_done = '0, e_valid = '0;
    logic [56:0] e_dna [3];
    logic [56:0] lat [3];
    int acnt = 0;

    int checks = 0, errors = 0;
    int age [3]  = '{default: 0};
    int rd_r [3] = '{default: 0};
    int sh_r [3] = '{default: 0};
    int brun [3] = '{default: 0};
    int nd [3]   = '{default: 0};
    logic [2:0] pclk = '0, prd = '0, psh = '0;
    logic [63:0] act_v, exp_v;
    int ph;
    bit end_req = 1'b0, end_ack = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        logic [56:0] sr = '0;
        red_pitaya_dna_ctrl #(.DNA_W(57), .CLK_DIV(g == 2 ? 2 : 4), .AUTO_START(g == 0 ? 1 : 0)) u_dut (
            .clk_i       (clk),
            .rstn_i      (rstn[g]),
            .start_i     (start[g]),
            .dna_dout_i  (dout[g]),
            .dna_clk_o   (dclk[g]),
            .dna_read_o  (rd[g]),
            .dna_shift_o (sh[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .valid_o     (valid[g]),
            .dna_o       (dna[g])
        );
        // DNA_PORT behaviour: READ loads the identifier, SHIFT moves the next bit to DOUT
        always @(posedge dclk[g]) sr <= rd[g] ? val[g] : sh[g] ? {sr[55:0], 1'b0} : sr;
        assign dout[g] = sr[56];
    end

    // timeline model: a readout keeps busy high for (2*57+1)*CLK_DIV cycles, then publishes the value
    always @(posedge clk) begin
        if (rstn[0]) acnt++;
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                rem[i] = 0; k[i] = 0; pend[i] = au[i];
                e_busy[i] = 1'b0; e_done[i] = 1'b0; e_valid[i] = 1'b0; e_dna[i] = '0;
            end else begin
                e_done[i] = 1'b0;
                if (rem[i] > 0) begin
                    rem[i]--; k[i]++;
                    if (rem[i] == 0) begin
                        e_done[i] = 1'b1; e_valid[i] = 1'b1; e_busy[i] = 1'b0; e_dna[i] = lat[i];
                        nexp[i]++;
                    end
                end else if (start[i] || pend[i]) begin
                    rem[i] = (2 * 57 + 1) * dv[i]; k[i] = 1; lat[i] = val[i];
                    e_busy[i] = 1'b1; e_valid[i] = 1'b0;
                end
                pend[i] = 1'b0;
            end
        end
    end

    task automatic check(input bit ok, input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, a, e);
        end
    endtask

    // compare every cycle and monitor the DNA_PORT protocol
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            ph = ((k[i] - 1) / dv[i]) % 2;
            exp_v = '0;
            if (rstn[i])
                exp_v = {1'b0, e_busy[i], e_done[i], e_valid[i], e_busy[i] & ph[0],
                         e_busy[i] & (k[i] <= 2 * dv[i]), e_busy[i] & (k[i] > 2 * dv[i]), e_dna[i]};
            act_v = {1'b0, busy[i], done[i], valid[i], dclk[i], rd[i], sh[i], dna[i]};
            check(act_v == exp_v, "outputs", i, act_v, exp_v);
            if (!rstn[i]) begin
                age[i] = 0; rd_r[i] = 0; sh_r[i] = 0; brun[i] = 0;
            end else begin
                age[i] = ({rd[i], sh[i]} != {prd[i], psh[i]}) ? 0 : age[i] + 1;
                if (dclk[i] && !pclk[i]) begin
                    check(age[i] >= dv[i], "setup", i, 64'(age[i]), 64'(dv[i]));
                    rd_r[i] += int'(rd[i]);
                    sh_r[i] += int'(sh[i]);
                end
                if (busy[i]) brun[i]++;
                if (done[i]) begin
                    check(rd_r[i] == 1, "read_edges", i, 64'(rd_r[i]), 64'd1);
                    check(sh_r[i] == 56, "shift_edges", i, 64'(sh_r[i]), 64'd56);
                    check(brun[i] == lit_l[i], "busy_width", i, 64'(brun[i]), 64'(lit_l[i]));
                    if (i != 2 && nd[i] == 0)
                        check(dna[i] == 57'h0823456789ABCDE, "dna_literal", i, 64'(dna[i]), 64'h0823456789ABCDE);
                    if (i == 2 && nd[i] == 0)
                        check(dna[i] == 57'h1FFFFFFFFFFFFFF, "dna_ones", i, 64'(dna[i]), 64'h1FFFFFFFFFFFFFF);
                    if (i == 2 && nd[i] == 1)
                        check(dna[i] == 57'h100000000000001, "dna_ends", i, 64'(dna[i]), 64'h100000000000001);
                    if (i == 0 && nd[i] == 0)
                        check(acnt - 1 == 460, "done_cycle", i, 64'(acnt - 1), 64'd460);
                    nd[i]++; rd_r[i] = 0; sh_r[i] = 0; brun[i] = 0;
                end
            end
            pclk[i] = dclk[i]; prd[i] = rd[i]; psh[i] = sh[i];
        end
        if (end_req && !end_ack) begin
            for (int i = 0; i < 3; i++) check(nd[i] == nexp[i], "done_count", i, 64'(nd[i]), 64'(nexp[i]));
            end_ack = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        val[0] = 57'h0823456789ABCDE;
        val[1] = 57'h0823456789ABCDE;
        val[2] = 57'h1FFFFFFFFFFFFFF;
        repeat (5) cyc();
        for (int t = 0; t < 1500; t++) begin
            rstn[0]  = !(t >= 900 && t < 903);
            rstn[1]  = 1'b1;
            rstn[2]  = 1'b1;
            start[0] = t == 600;
            start[1] = t == 100 || t == 110 || t == 300 || t == 560 || t == 561;
            start[2] = t == 0 || t == 300;
            if (t == 250) val[2] = 57'h100000000000001;
            cyc();
        end
        for (int n = 0; n < 20000; n++) begin
            for (int i = 0; i < 3; i++) begin
                rstn[i]  = $urandom_range(0, 2999) != 0;
                start[i] = $urandom_range(0, 63) == 0;
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) val[i] = {25'($urandom), $urandom};
            end
            cyc();
        end
        rstn = 3'b111;
        start = 3'b000;
        repeat (1200) cyc();
        end_req = 1'b1;
        repeat (3) @(negedge clk);
        if (!end_ack) begin
            errors++;
            $display("FAIL end_handshake: got 0 expected 1");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/red_pitaya_dna_ctrl.md
Name: red_pitaya_dna_ctrl

Overview:
Sequencer for the Xilinx DNA_PORT primitive. It generates the slow DNA clock and the READ/SHIFT controls, and deserialises the 57-bit device identifier MSB-first. It then presents the identifier as a stable parallel word to housekeeping and bus logic. Readout runs automatically after reset and again on request, replacing free-running counter-based sequencing with an explicit FSM and handshake.

Parameters:
DNA_W, 57, identifier width (number of bits sampled)
CLK_DIV, 4, clk_i cycles per DNA clock half-period; legal range 2..255
AUTO_START, 1, 1 = start one readout on the first clk_i edge after reset release

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  readout request, sampled high for one cycle; ignored while busy_o=1
dna_dout_i  in  1  DNA_PORT DOUT
dna_clk_o  out  1  DNA_PORT CLK
dna_read_o  out  1  DNA_PORT READ
dna_shift_o  out  1  DNA_PORT SHIFT
busy_o  out  1  readout in progress
done_o  out  1  one-cycle pulse when dna_o is updated
valid_o  out  1  dna_o holds a completed readout
dna_o  out  DNA_W  identifier, MSB = first bit shifted out

Behaviour:
- Interface: one clock, clk_i; reset rstn_i is asynchronous and active-low.
- Reset values: all outputs 0, dna_o = 0, state IDLE, divider and bit counter 0.
- All outputs are registered.
- States:
  - IDLE: dna_clk_o=0, dna_read_o=0, dna_shift_o=0.
  - LOAD: dna_read_o=1.
  - SHIFT: dna_shift_o=1.
  - DONE is not a held state; its actions occur on the final SHIFT edge.
- Start:
  - IDLE -> LOAD on start_i=1, or on the first edge after reset when AUTO_START=1.
  - On that same edge: busy_o=1, valid_o=0; dna_o retains its old value.
- DNA clock:
  - Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - READ and SHIFT change only on the first cycle of a low phase, giving CLK_DIV cycles of setup before the rising edge.
- LOAD: exactly one full period (2*CLK_DIV cycles), then -> SHIFT.
- SHIFT:
  - On the last cycle of every low phase: shreg <= {shreg[DNA_W-2:0], dna_dout_i}; bit_cnt++.
  - The first sample takes the bit presented by the load.
  - A high phase follows each sample except the DNA_W-th, so there are DNA_W samples and DNA_W-1 shift rising edges.
- Completion, on the edge of the DNA_W-th sample:
  - dna_o <= final shreg value, including this bit.
  - valid_o=1, done_o=1 for one cycle.
  - busy_o=0, all DNA_PORT controls 0, state -> IDLE.
- Latency: busy_o is high for exactly (2 + 2*DNA_W - 1)*CLK_DIV cycles, which is 460 cycles for the defaults.
- Boundaries:
  - start_i while busy has no effect and is not queued.
  - start_i on the done_o cycle is ignored (state still SHIFT on that edge).
  - start_i on the next cycle is accepted.
  - Reset mid-readout: immediate return to reset values, no done_o. With AUTO_START=1, readout restarts after release.
  - The bit counter must not wrap; the divider wraps at CLK_DIV-1.

Decomposition:
- Shared package red_pitaya_dna_pkg holds:
  - DNA_W_DEF = 57
  - state enum {IDLE, LOAD, SHIFT}
  - sim default DNA constant 57'h0823456789ABCDE
- Sub-module red_pitaya_dna_phase: CLK_DIV divider producing dna_clk and one-cycle strobes low_last/high_last, enabled by the FSM.
- The FSM, shift register and outputs live in the top module.

Test Plan:
- AUTO_START=1, DNA_PORT sim model with SIM_DNA_VALUE=57'h0823456789ABCDE -> done_o pulses once, exactly 460 cycles after the first post-reset edge; dna_o=57'h0823456789ABCDE; valid_o=1.
- Protocol monitor during readout -> READ high for exactly one rising edge of dna_clk_o; 56 SHIFT rising edges; READ and SHIFT never high together; no control change within CLK_DIV cycles before a rising edge.
- AUTO_START=0, idle for 100 cycles, then start_i pulse -> busy_o the next cycle, valid_o cleared, identical dna_o after 460 cycles.
- start_i pulsed at cycles 10 and 200 of a readout, and on the done_o cycle -> exactly one done_o; busy_o low after completion.
- rstn_i asserted at cycle 300 of a readout -> outputs 0 asynchronously, dna_o=0, no done_o; after release, a fresh readout returns the correct value.
- CLK_DIV=2 with DNA model value 57'h1FFFFFFFFFFFFFF, then 57'h100000000000001 -> correct values; busy_o width 230 cycles.
